adder_job_sequencer: RTL and testbench

- AXI4-Lite master that sequences the memory-mapped adder peripheral on behalf of one requester.
- Accepts an (A, B) job on a valid/ready port and writes A, then B, into the peripheral.
- Reads the result register twice: the peripheral computes on read and returns the previous sum, so read 1 primes and is discarded, and read 2 returns A+B.
- Returns the sum and a sticky error flag on a valid/ready result port. Sits between PS-side software glue or a DMA front end and the adder slave.

---
 rtl/adder_job_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_adder_job_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_job_sequencer.sv
// adder_job_sequencer
//   AXI4-Lite master that runs one (A, B) job against the memory-mapped adder
//   peripheral. It writes A to BASE+0x00 and B to BASE+0x04, then reads the
//   result register at BASE+0x48 twice. The peripheral computes on read and
//   returns the previous sum, so the first read only primes it and the second
//   read returns A+B.
//
//   Ports
//     axi_aclk / axi_areset      clock, asynchronous active-high reset
//     job_valid/ready, job_a/b   job request (valid/ready)
//     res_valid/ready, res_sum,  result; res_err is the OR of every non-OKAY
//     res_err                    BRESP/RRESP seen during the job
//     busy                       high whenever the sequencer is not idle
//     m_axi_*                    AXI4-Lite master (AW, W, B, AR, R)
module adder_job_sequencer #(
  parameter int                          C_AXI_DATA_WIDTH = 32,
  parameter int                          C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [C_AXI_DATA_WIDTH-1:0] job_a,
  input  logic [C_AXI_DATA_WIDTH-1:0] job_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [C_AXI_DATA_WIDTH-1:0] res_sum,
  output logic                        res_err,
  output logic                        busy,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_A   = BASE_ADDR;
  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_B   = BASE_ADDR + C_AXI_ADDR_WIDTH'(4);
  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_RES = BASE_ADDR + C_AXI_ADDR_WIDTH'(72);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_RD_PRIME, S_RD_RES, S_DONE
  } state_t;

  state_t                        state_q,   state_d;
  logic [C_AXI_DATA_WIDTH-1:0]   b_q,       b_d;
  logic [C_AXI_DATA_WIDTH-1:0]   sum_q,     sum_d;
  logic                          err_q,     err_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q,  wvalid_d;
  logic                          bready_q,  bready_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   araddr_q,  araddr_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q,  rready_d;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q   <= S_IDLE;
      b_q       <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    sum_d     = sum_q;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          // A goes straight into the write-data register; only B needs holding.
          b_d       = job_b;
          err_d     = 1'b0;
          awaddr_d  = ADDR_A;
          wdata_d   = job_a;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_A;
        end
      end

      S_WR_A, S_WR_B: begin
        if (bready_q && m_axi_bvalid) begin
          err_d    = err_q | (m_axi_bresp != 2'b00);
          bready_d = 1'b0;
          if (state_q == S_WR_A) begin
            awaddr_d  = ADDR_B;
            wdata_d   = b_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_B;
          end else begin
            araddr_d  = ADDR_RES;
            arvalid_d = 1'b1;
            state_d   = S_RD_PRIME;
          end
        end else begin
          // AW and W retire independently; B is accepted only once both have.
          awvalid_d = awvalid_q && !m_axi_awready;
          wvalid_d  = wvalid_q  && !m_axi_wready;
          bready_d  = !awvalid_d && !wvalid_d;
        end
      end

      S_RD_PRIME, S_RD_RES: begin
        if (rready_q && m_axi_rvalid) begin
          err_d    = err_q | (m_axi_rresp != 2'b00);
          rready_d = 1'b0;
          if (state_q == S_RD_PRIME) begin
            // Primed read returns the stale sum; drop it and read again.
            arvalid_d = 1'b1;
            state_d   = S_RD_RES;
          end else begin
            sum_d   = m_axi_rdata;
            state_d = S_DONE;
          end
        end else begin
          arvalid_d = arvalid_q && !m_axi_arready;
          rready_d  = !arvalid_d;
        end
      end

      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign job_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign res_valid     = (state_q == S_DONE);
  assign res_sum       = sum_q;
  assign res_err       = err_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_job_sequencer.sv
// Directed bench for adder_job_sequencer with a behavioural adder slave
// (computes on read, returns the previous sum; optional AWREADY delay and
// error BRESP on the B-register write).
module tb_adder_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [31:0] job_a, job_b;
  logic        res_valid, res_ready;
  logic [31:0] res_sum;
  logic        res_err, busy;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_job_sequencer #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32), .BASE_ADDR(32'h0)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_err(res_err), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  bit          err_on_b = 1'b0;
  int          aw_wait;
  logic        aw_have, w_have;
  logic [31:0] aw_addr_s, w_data_s, reg_a, reg_b, prev_sum;

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
  assign m_axi_wready  = m_axi_wvalid;
  assign m_axi_arready = m_axi_arvalid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; aw_have <= 1'b0; w_have <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; reg_a <= '0; reg_b <= '0; prev_sum <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_have <= 1'b1; aw_addr_s <= m_axi_awaddr; aw_wait <= 0;
      end else if (m_axi_awvalid) aw_wait <= aw_wait + 1;
      if (m_axi_wvalid && m_axi_wready) begin
        w_have <= 1'b1; w_data_s <= m_axi_wdata;
      end
      if (aw_have && w_have && !m_axi_bvalid) begin
        if (aw_addr_s == 32'h0) reg_a <= w_data_s;
        else if (aw_addr_s == 32'h4) reg_b <= w_data_s;
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= (err_on_b && aw_addr_s == 32'h4) ? 2'b10 : 2'b00;
        aw_have <= 1'b0; w_have <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1; m_axi_rdata <= prev_sum; m_axi_rresp <= 2'b00;
        prev_sum <= reg_a + reg_b;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- transaction log + protocol monitor ----------------
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int          proto = 0;
  logic        pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0;
  logic [31:0] p_awaddr = 0, p_wdata = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) aw_log.push_back(m_axi_awaddr);
      if (m_axi_wvalid && m_axi_wready)   w_log.push_back(m_axi_wdata);
      if (m_axi_arvalid && m_axi_arready) ar_log.push_back(m_axi_araddr);
      // a valid without its handshake must stay up with stable payload
      if (pv_aw && !pr_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) proto <= proto + 1;
      if (pv_w  && !pr_w  && (!m_axi_wvalid  || m_axi_wdata  != p_wdata))  proto <= proto + 1;
    end
    pv_aw <= m_axi_awvalid; pr_aw <= m_axi_awready; p_awaddr <= m_axi_awaddr;
    pv_w  <= m_axi_wvalid;  pr_w  <= m_axi_wready;  p_wdata  <= m_axi_wdata;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers a job and returns at the negedge after the accepting edge.
  task automatic start_job(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    job_valid = 1'b1; job_a = a; job_b = b;
    n = 0;
    while (!job_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  // Cycles from the accepting edge to res_valid.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 60) begin @(negedge clk); lat++; end
    chk("res_valid_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  // Holds res_ready low for `hold` cycles checking stability, then takes result.
  task automatic take_res(input string tag, input int hold,
                          input logic [31:0] exp_sum, input logic exp_err);
    chk({tag, "_sum"}, res_sum, exp_sum);
    chk({tag, "_err"}, {31'd0, res_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, {29'd0, res_valid, job_ready, busy}, 32'b101);
      chk({tag, "_hold_sum"}, res_sum, exp_sum);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_after_take"}, {29'd0, res_valid, job_ready, busy}, 32'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, n, c, nres, nacc, res0_cyc, acc2_cyc, overlap;
    bit drop_next;
    logic [31:0] sums[2];

    rst = 1'b1; job_valid = 1'b0; job_a = '0; job_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready_busy_vld", {29'd0, job_ready, busy, res_valid}, 32'b100);
    chk("rst_sum", res_sum, 32'd0);
    chk("rst_axi_valids",
        {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, res_err},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic 5 + 7, address/data order and latency
    aw_log.delete(); w_log.delete(); ar_log.delete();
    start_job(32'd5, 32'd7);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
    wait_res(lat);
    chk("t1_latency_le14", {31'd0, (lat <= 14)}, 32'd1);
    take_res("t1", 0, 32'd12, 1'b0);
    chk("t1_aw_cnt", aw_log.size(), 32'd2);
    chk("t1_aw0", aw_log[0], 32'h0);
    chk("t1_aw1", aw_log[1], 32'h4);
    chk("t1_w0", w_log[0], 32'd5);
    chk("t1_w1", w_log[1], 32'd7);
    chk("t1_ar_cnt", ar_log.size(), 32'd2);
    chk("t1_ar0", ar_log[0], 32'h48);
    chk("t1_ar1", ar_log[1], 32'h48);

    // 2: wrap-around, then a job whose primed read returns the stale 1
    start_job(32'hFFFF_FFFF, 32'd2);
    wait_res(lat);
    take_res("t2_ovf", 0, 32'd1, 1'b0);
    start_job(32'd3, 32'd4);
    wait_res(lat);
    take_res("t2_next", 0, 32'd7, 1'b0);

    // 3: error BRESP on the B write; sequence still completes
    err_on_b = 1'b1;
    ar_log.delete();
    start_job(32'd20, 32'd22);
    wait_res(lat);
    chk("t3_ar_cnt", ar_log.size(), 32'd2);
    take_res("t3_err", 0, 32'd42, 1'b1);
    err_on_b = 1'b0;
    start_job(32'd1, 32'd2);
    wait_res(lat);
    take_res("t3_clean", 0, 32'd3, 1'b0);

    // 4: AWREADY delayed 3 cycles; result back-pressured 10 cycles
    aw_delay = 3;
    aw_log.delete(); w_log.delete();
    start_job(32'd100, 32'd23);
    chk("t4_both_valid", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'b11);
    @(negedge clk);
    chk("t4_w_dropped", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'b10);
    @(negedge clk);
    chk("t4_aw_held", {30'd0, m_axi_awvalid, m_axi_bready}, 32'b10);
    wait_res(lat);
    take_res("t4", 10, 32'd123, 1'b0);
    chk("t4_aw_cnt", aw_log.size(), 32'd2);
    chk("t4_w_cnt", w_log.size(), 32'd2);
    aw_delay = 0;

    // 5: reset during RD_PRIME
    start_job(32'd9, 32'd9);
    n = 0;
    while (!m_axi_arvalid && n < 40) begin @(negedge clk); n++; end
    chk("t5_reach_rd_prime", {31'd0, m_axi_arvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", {29'd0, job_ready, busy, res_valid}, 32'b100);
    chk("t5_rst_axi",
        {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, res_err},
        32'd0);
    chk("t5_rst_sum", res_sum, 32'd0);
    chk("t5_rst_araddr", m_axi_araddr, 32'd0);
    chk("t5_rst_awaddr", m_axi_awaddr, 32'd0);
    chk("t5_rst_wdata", m_axi_wdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    start_job(32'd1, 32'd1);
    wait_res(lat);
    take_res("t5_after", 0, 32'd2, 1'b0);

    // 6: back-to-back with job_valid and res_ready held high
    @(negedge clk);
    job_a = 32'd10; job_b = 32'd20; job_valid = 1'b1; res_ready = 1'b1;
    c = 0; nres = 0; nacc = 0; res0_cyc = 0; acc2_cyc = 0; overlap = 0; drop_next = 1'b0;
    sums[0] = '0; sums[1] = '0;
    while (nres < 2 && c < 200) begin
      if (drop_next) begin job_valid = 1'b0; drop_next = 1'b0; end
      if (nacc == 1 && job_a == 32'd10) begin job_a = 32'd30; job_b = 32'd40; end
      if (res_valid && job_ready) overlap++;
      if (res_valid && res_ready) begin
        if (nres == 0) res0_cyc = c;
        sums[nres] = res_sum;
        nres++;
      end
      if (job_valid && job_ready) begin
        nacc++;
        if (nacc == 2) begin acc2_cyc = c; drop_next = 1'b1; end
      end
      @(negedge clk);
      c++;
    end
    job_valid = 1'b0; res_ready = 1'b0;
    chk("t6_results", nres, 32'd2);
    chk("t6_sum0", sums[0], 32'd30);
    chk("t6_sum1", sums[1], 32'd70);
    chk("t6_accept_gap", acc2_cyc - res0_cyc, 32'd1);
    chk("t6_no_overlap", overlap, 32'd0);

    chk("axi_valid_stability", proto, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
